// File: rtl/pc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_pkg: shared PC width, reset value and next-PC select encoding      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pc_pkg;

  localparam int              PC_WIDTH = 8;
  localparam logic [7:0]      PC_RESET = 8'h00;

  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_RET    = 3'd1,
    SEL_CALL   = 3'd2,
    SEL_JUMP   = 3'd3,
    SEL_BRANCH = 3'd4,
    SEL_SEQ    = 3'd5
  } pc_sel_t;

endpackage
`default_nettype wire

// File: rtl/return_addr_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | return_addr_stack: circular return-address stack with depth counter   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module return_addr_stack
  import pc_pkg::*;
#(
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic [PC_WIDTH-1:0]            i_push_data,
  output logic [PC_WIDTH-1:0]            o_top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] o_depth,
  output logic                           o_overflow,
  output logic                           o_underflow
);

  localparam int AW = $clog2(RAS_DEPTH);
  localparam int DW = $clog2(RAS_DEPTH+1);
  localparam logic [DW-1:0] c_FULL = DW'(RAS_DEPTH);

  logic [PC_WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [AW-1:0]       r_ptr;
  logic [DW-1:0]       r_depth;
  logic [AW-1:0]       w_wr_idx;
  logic                w_full;
  logic                w_empty;

  // When full, the slot after the top is the oldest entry, so a push wraps onto it.
  assign w_wr_idx    = r_ptr + AW'(1);
  assign w_full      = (r_depth == c_FULL);
  assign w_empty     = (r_depth == '0);
  assign o_top       = r_mem[r_ptr];
  assign o_depth     = r_depth;
  assign o_overflow  = i_push && w_full;
  assign o_underflow = i_pop && w_empty;

  always_ff @(posedge clk) begin
    if (i_push && !reset) begin
      r_mem[w_wr_idx] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_depth <= '0;
    end else if (i_pop) begin
      if (!w_empty) begin
        r_ptr   <= r_ptr - AW'(1);
        r_depth <= r_depth - DW'(1);
      end
    end else if (i_push) begin
      r_ptr <= w_wr_idx;
      if (!w_full) begin
        r_depth <= r_depth + DW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/next_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | next_pc_unit: priority next-PC select with return-address stack       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module next_pc_unit
  import pc_pkg::*;
#(
  parameter int         RAS_DEPTH = 4,
  parameter logic [7:0] PC_STEP   = 8'd4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PC_WIDTH-1:0]            pc,
  input  logic                           stall,
  input  logic                           branch_taken,
  input  logic [PC_WIDTH-1:0]            branch_offset,
  input  logic                           jump,
  input  logic                           call,
  input  logic                           ret,
  input  logic [PC_WIDTH-1:0]            jump_target,
  output logic [PC_WIDTH-1:0]            next_pc,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_depth,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  pc_sel_t             w_sel;
  logic [PC_WIDTH-1:0] w_seq_pc;
  logic [PC_WIDTH-1:0] w_br_pc;
  logic [PC_WIDTH-1:0] w_ras_top;
  logic [$clog2(RAS_DEPTH+1)-1:0] w_depth;
  logic                w_push;
  logic                w_pop;
  logic                w_ovf_pulse;
  logic                w_unf_pulse;
  logic                r_overflow;
  logic                r_underflow;

  assign w_seq_pc = pc + PC_STEP;
  assign w_br_pc  = pc + branch_offset;

  always_comb begin
    w_sel = SEL_SEQ;
    if (stall)             w_sel = SEL_HOLD;
    else if (ret)          w_sel = SEL_RET;
    else if (call)         w_sel = SEL_CALL;
    else if (jump)         w_sel = SEL_JUMP;
    else if (branch_taken) w_sel = SEL_BRANCH;
  end

  assign w_push = !reset && (w_sel == SEL_CALL);
  assign w_pop  = !reset && (w_sel == SEL_RET);

  return_addr_stack #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_seq_pc),
    .o_top       (w_ras_top),
    .o_depth     (w_depth),
    .o_overflow  (w_ovf_pulse),
    .o_underflow (w_unf_pulse)
  );

  always_comb begin
    next_pc = PC_RESET;
    if (!reset) begin
      case (w_sel)
        SEL_HOLD:   next_pc = pc;
        // An empty stack falls through to the sequential address.
        SEL_RET:    next_pc = (w_depth != '0) ? w_ras_top : w_seq_pc;
        SEL_CALL:   next_pc = jump_target;
        SEL_JUMP:   next_pc = jump_target;
        SEL_BRANCH: next_pc = w_br_pc;
        SEL_SEQ:    next_pc = w_seq_pc;
        default:    next_pc = PC_RESET;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_pulse) r_overflow  <= 1'b1;
      if (w_unf_pulse) r_underflow <= 1'b1;
    end
  end

  assign ras_depth     = w_depth;
  assign ras_overflow  = r_overflow;
  assign ras_underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_next_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_next_pc_unit: directed scoreboard bench for next_pc_unit           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_next_pc_unit;

  typedef struct {
    string      tag;
    logic [7:0] nxt;
    logic [2:0] dep;
    logic       ovf;
    logic       unf;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pc;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_offset;
  logic       jump;
  logic       call;
  logic       ret;
  logic [7:0] jump_target;
  logic [7:0] next_pc;
  logic [2:0] ras_depth;
  logic       ras_overflow;
  logic       ras_underflow;

  exp_t q_exp[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  next_pc_unit #(.RAS_DEPTH(4), .PC_STEP(8'd4)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .call          (call),
    .ret           (ret),
    .jump_target   (jump_target),
    .next_pc       (next_pc),
    .ras_depth     (ras_depth),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  // Inputs: rst, stall, branch, offset, jump, call, ret, target, pc.
  // Expected values are for the cycle itself: next_pc now, state before the edge.
  task automatic step(input string tag,
                      input logic r, input logic st, input logic br, input logic [7:0] off,
                      input logic jp, input logic cl, input logic rt, input logic [7:0] tgt,
                      input logic [7:0] p,
                      input logic [7:0] e_nxt, input logic [2:0] e_dep,
                      input logic e_ovf, input logic e_unf);
    exp_t e;
    exp_t g;
    @(negedge clk);
    reset = r; stall = st; branch_taken = br; branch_offset = off;
    jump = jp; call = cl; ret = rt; jump_target = tgt; pc = p;
    e.tag = tag; e.nxt = e_nxt; e.dep = e_dep; e.ovf = e_ovf; e.unf = e_unf;
    q_exp.push_back(e);
    #2;
    g = q_exp.pop_front();
    checks++;
    assert (next_pc === g.nxt) else begin
      errors++;
      $error("FAIL %s next_pc got %h exp %h", g.tag, next_pc, g.nxt);
    end
    checks++;
    assert (ras_depth === g.dep) else begin
      errors++;
      $error("FAIL %s ras_depth got %0d exp %0d", g.tag, ras_depth, g.dep);
    end
    checks++;
    assert (ras_overflow === g.ovf) else begin
      errors++;
      $error("FAIL %s ras_overflow got %b exp %b", g.tag, ras_overflow, g.ovf);
    end
    checks++;
    assert (ras_underflow === g.unf) else begin
      errors++;
      $error("FAIL %s ras_underflow got %b exp %b", g.tag, ras_underflow, g.unf);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset = 8'h00;
    jump = 1'b0; call = 1'b0; ret = 1'b0; jump_target = 8'h00; pc = 8'h33;
    @(posedge clk);
    //    tag          rst st br off    jp cl rt tgt    pc     nxt    dep ovf unf
    step("reset",      1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h33, 8'h00, 0, 0, 0);
    step("idle",       0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h10, 8'h14, 0, 0, 0);
    step("br_neg",     0, 0, 1, 8'hF0, 0, 0, 0, 8'h00, 8'h20, 8'h10, 0, 0, 0);
    step("jmp_ov_br",  0, 0, 1, 8'hF0, 1, 0, 0, 8'h80, 8'h20, 8'h80, 0, 0, 0);
    step("jmp",        0, 0, 0, 8'h00, 1, 0, 0, 8'hC8, 8'h10, 8'hC8, 0, 0, 0);
    step("br_wrap",    0, 0, 1, 8'h20, 0, 0, 0, 8'h00, 8'hF0, 8'h10, 0, 0, 0);
    step("call1",      0, 0, 0, 8'h00, 0, 1, 0, 8'h90, 8'h30, 8'h90, 0, 0, 0);
    step("ret1",       0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h90, 8'h34, 1, 0, 0);
    step("callA",      0, 0, 0, 8'h00, 0, 1, 0, 8'h90, 8'h00, 8'h90, 0, 0, 0);
    step("callB",      0, 0, 0, 8'h00, 0, 1, 0, 8'h90, 8'h10, 8'h90, 1, 0, 0);
    step("callC",      0, 0, 0, 8'h00, 0, 1, 0, 8'h90, 8'h20, 8'h90, 2, 0, 0);
    step("callD",      0, 0, 0, 8'h00, 0, 1, 0, 8'h90, 8'h30, 8'h90, 3, 0, 0);
    step("callE_full", 0, 0, 0, 8'h00, 0, 1, 0, 8'h90, 8'h40, 8'h90, 4, 0, 0);
    step("retA",       0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h90, 8'h44, 4, 1, 0);
    step("retB",       0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h90, 8'h34, 3, 1, 0);
    step("retC",       0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h90, 8'h24, 2, 1, 0);
    step("retD",       0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h90, 8'h14, 1, 1, 0);
    step("ret_empty",  0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h60, 8'h64, 0, 1, 0);
    step("unf_sticky", 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h60, 8'h64, 0, 1, 1);
    step("stall_call", 0, 1, 0, 8'h00, 0, 1, 0, 8'h90, 8'h50, 8'h50, 0, 1, 1);
    step("post_stall", 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h50, 8'h54, 0, 1, 1);
    step("call_pre",   0, 0, 0, 8'h00, 0, 1, 0, 8'hA0, 8'h50, 8'hA0, 0, 1, 1);
    step("call_ret",   0, 0, 0, 8'h00, 0, 1, 1, 8'h90, 8'hA0, 8'h54, 1, 1, 1);
    step("after_cr",   0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h54, 8'h58, 0, 1, 1);
    step("seq_wrap",   0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'hFC, 8'h00, 0, 1, 1);
    step("fill1",      0, 0, 0, 8'h00, 0, 1, 0, 8'h40, 8'h00, 8'h40, 0, 1, 1);
    step("fill2",      0, 0, 0, 8'h00, 0, 1, 0, 8'h40, 8'h04, 8'h40, 1, 1, 1);
    step("fill3",      0, 0, 0, 8'h00, 0, 1, 0, 8'h40, 8'h08, 8'h40, 2, 1, 1);
    step("depth3",     0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h40, 8'h44, 3, 1, 1);
    step("rst_assert", 1, 0, 0, 8'h00, 0, 1, 0, 8'h90, 8'h40, 8'h00, 3, 1, 1);
    step("rst_hold",   1, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h40, 8'h00, 0, 0, 0);
    step("post_rst",   0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h10, 8'h14, 0, 0, 0);
    step("ret_cleared",0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h20, 8'h24, 0, 0, 0);
    step("unf_again",  0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h20, 8'h24, 0, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/next_pc_unit.md
# next_pc_unit

Next-program-counter generator for the single-cycle core. It sits directly upstream of the 8-bit PC register and drives that register's data input every cycle. It selects among sequential fetch, relative branch, absolute jump, call and return. It keeps a small return-address stack (RAS) so that call/return pairs resolve without going through the register file.

## Interface
- RAS_DEPTH, 4, number of return-address entries (power of two, ≥2)
- PC_STEP, 8'd4, sequential increment added to pc
- clk  input  1  rising-edge clock
- reset  input  1  reset reset, synchronous, active-high; clock clk
- pc  input  8  current PC (PC register output)
- stall  input  1  hold PC; all other controls ignored
- branch_taken  input  1  take relative branch
- branch_offset  input  8  two's-complement offset added to pc
- jump  input  1  absolute jump to jump_target
- call  input  1  jump to jump_target and push return address
- ret  input  1  return to address on top of RAS
- jump_target  input  8  absolute target for jump/call
- next_pc  output  8  value for PC register d input
- ras_depth  output  $clog2(RAS_DEPTH+1)  valid entries in RAS
- ras_overflow  output  1  sticky: call issued with RAS full
- ras_underflow  output  1  sticky: ret issued with RAS empty

## Operation
- Fixed priority each cycle: reset > stall > ret > call > jump > branch_taken > sequential.
- reset: next_pc = 8'h00; RAS emptied, ras_depth = 0, both sticky flags cleared.
- stall: next_pc = pc; RAS and flags unchanged.
- ret, depth>0: next_pc = top entry; pop (depth−1).
- ret, depth=0: next_pc = pc + PC_STEP; ras_underflow set; depth stays 0.
- call: next_pc = jump_target; push pc + PC_STEP. If depth = RAS_DEPTH, the oldest entry is overwritten (circular), depth stays RAS_DEPTH, ras_overflow set.
- jump: next_pc = jump_target.
- branch_taken: next_pc = pc + branch_offset.
- otherwise: next_pc = pc + PC_STEP.
- All additions are 8-bit, modulo 256; the carry is discarded (0xFC + 4 = 0x00).
- call and ret together: ret wins, no push. This is a legal input and is not flagged.
- Sticky flags clear only on reset.

## Timing
- next_pc is combinational from the inputs and the current RAS top: zero-cycle latency, so the PC register captures it on the same edge.
- RAS push/pop, ras_depth and flag updates take effect on the rising clk edge. A call in cycle N is visible to a ret in cycle N+1.
- reset is sampled on the rising edge. A reset asserted mid call/ret sequence discards all stack contents. During reset cycles next_pc = 8'h00 combinationally.
- Outputs after reset: next_pc = 8'h00 (while reset high), ras_depth = 0, ras_overflow = 0, ras_underflow = 0.

## Structure
- Shared package pc_pkg:
  - PC_WIDTH = 8, PC_RESET = 8'h00
  - pc_sel_t enum: SEL_HOLD, SEL_RET, SEL_CALL, SEL_JUMP, SEL_BRANCH, SEL_SEQ
- One sub-module, return_addr_stack, parameterised by RAS_DEPTH.
  - Circular buffer, top pointer, depth counter.
  - push/pop/top ports; overflow/underflow pulse outputs.
- next_pc_unit holds the priority decode to pc_sel_t, the adders, the output mux and the sticky flag registers.

## Test plan
- Reset, then idle with pc = 0x10 → next_pc = 0x14; ras_depth = 0; flags 0.
- pc = 0x20, branch_taken, branch_offset = 0xF0 (−16) → next_pc = 0x10. Same cycle with jump = 1, jump_target = 0x80 → next_pc = 0x80.
- call at pc = 0x30, target 0x90 → next_pc = 0x90, depth 1. Next cycle ret → next_pc = 0x34, depth 0.
- Five calls from pc = 0x00, 0x10, 0x20, 0x30, 0x40 with RAS_DEPTH = 4 → ras_overflow = 1, depth 4. Four rets yield 0x44, 0x34, 0x24, 0x14. A fifth ret → next_pc = pc + 4, ras_underflow = 1.
- stall together with call, pc = 0x50 → next_pc = 0x50, depth unchanged. call + ret together → ret behaviour, no push.
- pc = 0xFC, sequential → next_pc = 0x00. Reset asserted with depth 3 and flags set → depth 0, flags 0, next_pc = 0x00.
